// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: opcodes, ImmSrc codes,
// FSM states, error codes, immediate range limits and the latched request.
package instr_enc_pkg;

  // Opcodes of the supported op set (RV32I subset)
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // ImmSrc codes as used by the controller; IMMSRC_NONE marks R-type
  localparam logic [2:0] IMMSRC_I    = 3'b000;
  localparam logic [2:0] IMMSRC_S    = 3'b001;
  localparam logic [2:0] IMMSRC_B    = 3'b010;
  localparam logic [2:0] IMMSRC_J    = 3'b011;
  localparam logic [2:0] IMMSRC_U    = 3'b100;
  localparam logic [2:0] IMMSRC_NONE = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OP    = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_ALIGN = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2
  } state_e;

  // Signed immediate limits per format
  localparam logic signed [31:0] IMM_I_MIN  = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX  =  32'sd2047;
  localparam logic        [31:0] IMM_SH_MAX =  32'd31;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX  =  32'sd1048574;

  // Request fields as latched on accept
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] imm;
  } req_t;

  // Opcode -> immediate format class
  function automatic logic [2:0] decode_immsrc(input logic [6:0] op);
    logic [2:0] src;
    src = IMMSRC_NONE;
    case (op)
      OP_LW, OP_IALU: src = IMMSRC_I;
      OP_SW:          src = IMMSRC_S;
      OP_BEQ:         src = IMMSRC_B;
      OP_JAL:         src = IMMSRC_J;
      OP_LUI:         src = IMMSRC_U;
      default:        src = IMMSRC_NONE;
    endcase
    return src;
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_IALU, OP_JAL, OP_LUI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational packer: builds the 32-bit instruction word for one ImmSrc
// class and reports whether the immediate is aligned and in range.
module imm_packer
  import instr_enc_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  req_t        req_i,
  output logic [31:0] instr_o,
  output logic        range_ok_o,
  output logic        align_ok_o
);

  logic signed [31:0] imm_s;
  logic               is_shift;

  assign imm_s = $signed(req_i.imm);

  // Pack fields per format; fields a format does not use stay zero
  always_comb begin
    instr_o    = 32'd0;
    range_ok_o = 1'b1;
    align_ok_o = 1'b1;
    is_shift   = (req_i.op == OP_IALU) &&
                 ((req_i.funct3 == 3'b001) || (req_i.funct3 == 3'b101));
    case (imm_src_i)
      IMMSRC_I: begin
        if (is_shift) begin
          instr_o    = {1'b0, req_i.funct7_5, 5'b00000, req_i.imm[4:0], req_i.rs1,
                        req_i.funct3, req_i.rd, req_i.op};
          // Shift amounts are unsigned; negative values read as huge
          range_ok_o = (req_i.imm <= IMM_SH_MAX);
        end else begin
          instr_o    = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.op};
          range_ok_o = (imm_s >= IMM_I_MIN) && (imm_s <= IMM_I_MAX);
        end
      end
      IMMSRC_S: begin
        instr_o    = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                      req_i.imm[4:0], req_i.op};
        range_ok_o = (imm_s >= IMM_I_MIN) && (imm_s <= IMM_I_MAX);
      end
      IMMSRC_B: begin
        instr_o    = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                      req_i.imm[4:1], req_i.imm[11], req_i.op};
        range_ok_o = (imm_s >= IMM_B_MIN) && (imm_s <= IMM_B_MAX);
        align_ok_o = (req_i.imm[0] == 1'b0);
      end
      IMMSRC_J: begin
        instr_o    = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11], req_i.imm[19:12],
                      req_i.rd, req_i.op};
        range_ok_o = (imm_s >= IMM_J_MIN) && (imm_s <= IMM_J_MAX);
        align_ok_o = (req_i.imm[0] == 1'b0);
      end
      IMMSRC_U: begin
        instr_o    = {req_i.imm[31:12], req_i.rd, req_i.op};
        align_ok_o = (req_i.imm[11:0] == 12'd0);
      end
      IMMSRC_NONE: begin
        instr_o = {1'b0, req_i.funct7_5, 5'b00000, req_i.rs2, req_i.rs1,
                   req_i.funct3, req_i.rd, req_i.op};
      end
      default: instr_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder: accepts instruction fields, packs them into an RV32I
// word, checks the immediate and writes the word to instruction memory at an
// auto-incrementing word address.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, when not full and when flush is low; the
// requester must hold its fields stable while req_valid is high and waiting.
module instruction_encoder
  import instr_enc_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              enc_error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output state_e            dbg_state
);

  localparam logic [ADDR_W:0]   CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  req_t              req_in;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              enc_error_q, enc_error_d;
  err_code_e         err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [2:0]        imm_src;
  logic              op_ok;
  logic [31:0]       packed_word;
  logic              range_ok;
  logic              align_ok;
  err_code_e         chk_code;
  logic              accept;

  assign req_in  = {op, rd, rs1, rs2, funct3, funct7_5, imm};
  assign imm_src = decode_immsrc(req_q.op);
  assign op_ok   = op_supported(req_q.op);

  imm_packer u_imm_packer (
    .imm_src_i  (imm_src),
    .req_i      (req_q),
    .instr_o    (packed_word),
    .range_ok_o (range_ok),
    .align_ok_o (align_ok)
  );

  // Error priority: unsupported op, then misalignment, then range
  always_comb begin
    chk_code = ERR_NONE;
    if (!op_ok)         chk_code = ERR_OP;
    else if (!align_ok) chk_code = ERR_ALIGN;
    else if (!range_ok) chk_code = ERR_RANGE;
  end

  assign full       = (count_q == CAP);
  assign req_ready  = (state_q == S_IDLE) && !full && !flush;
  assign accept     = req_valid && req_ready;
  assign mem_we     = mem_we_q;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = wdata_q;
  assign enc_error  = enc_error_q;
  assign error_code = err_q;
  assign count      = count_q;
  assign dbg_state  = state_q;

  // Next-state and output-register logic; flush overrides every state
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_we_d    = 1'b0;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    enc_error_d = 1'b0;
    err_d       = err_q;
    count_d     = count_q;
    if (flush) begin
      state_d = S_IDLE;
      ptr_d   = BASE_ADDR;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_d   = req_in;
            err_d   = ERR_NONE;
            state_d = S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (chk_code == ERR_NONE) begin
            wdata_d  = packed_word;
            mem_we_d = 1'b1;
            state_d  = S_WRITE;
          end else begin
            enc_error_d = 1'b1;
            err_d       = chk_code;
            state_d     = S_IDLE;
          end
        end
        S_WRITE: begin
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      mem_we_q    <= 1'b0;
      ptr_q       <= BASE_ADDR;
      wdata_q     <= 32'd0;
      enc_error_q <= 1'b0;
      err_q       <= ERR_NONE;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_we_q    <= mem_we_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      enc_error_q <= enc_error_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

endmodule
